serial_adder: RTL and testbench

Bit-serial, LSB-first adder that applies a single one-bit full-adder cell once per clock, with a registered carry fed back as the next bit's carry-in. It replaces a WIDTH-wide ripple chain with one cell plus shift registers. It sits directly downstream of the operand source and consumes that cell's Sum_out/Cout every cycle. The result is presented as a parallel word with a start/done handshake.

---
 rtl/serial_adder_pkg.sv | 29 ++
 rtl/serial_adder_if.sv | 57 +++++
 rtl/serial_adder_full_adder_cell.sv | 31 +++
 rtl/serial_adder.sv | 179 +++++++++++++++++
 tb/tb_serial_adder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared definitions for the bit-serial adder: FSM state
//                encoding, the default operand width and a helper that
//                sizes the bit counter.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

  // Default operand/result width; legal range is 2..32.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller states. Encodings are fixed so they can be observed
  // consistently in waveforms and by software-visible debug taps.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width. One bit wider than strictly needed so the counter
  // can represent WIDTH itself and never wraps, even at WIDTH=32.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_if
//  Description : Request/result bundle of the bit-serial adder.
//                master : operand source (drives start/a/b/cin, sees results)
//                slave  : the adder itself
//  Signals     : start        request, sampled on rising clk
//                a, b         operands, captured when start is accepted
//                cin          initial carry-in, captured with the operands
//                busy         addition in progress
//                done         one-cycle result-valid pulse
//                sum, cout    result word and final carry, held until the
//                             first bit edge of the next operation
//                ovf          signed overflow (only with OVERFLOW_EN)
//  Config      : OVERFLOW_EN  adds the ovf signal
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef OVERFLOW_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif

endinterface : serial_adder_if
`default_nettype wire

// File: rtl/serial_adder_full_adder_cell.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_cell
//  Description : Gate-level one-bit full adder built from xor/and/or
//                primitives. Purely combinational.
//  Ports       : D1, D2   operand bits
//                Cin      carry in
//                Sum_out  D1 ^ D2 ^ Cin
//                Cout     generate | (propagate & Cin)
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder_cell (
  input  wire D1,
  input  wire D2,
  input  wire Cin,
  output wire Sum_out,
  output wire Cout
);

  wire w_prop;  // propagate: D1 ^ D2
  wire w_gen;   // generate:  D1 & D2
  wire w_pc;    // propagated carry: propagate & Cin

  xor u_xor_prop (w_prop, D1, D2);
  xor u_xor_sum  (Sum_out, w_prop, Cin);
  and u_and_gen  (w_gen, D1, D2);
  and u_and_pc   (w_pc, w_prop, Cin);
  or  u_or_cout  (Cout, w_gen, w_pc);

endmodule : full_adder_cell
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial LSB-first adder. A single full_adder_cell is
//                applied once per clock with its carry registered and fed
//                back. Operands are shifted out of two shift registers and
//                the sum bits are shifted into the MSB of a result shift
//                register, so after WIDTH bit edges the result register holds
//                the full parallel word.
//  Ports       : clk      rising-edge clock
//                rst_n    asynchronous active-low reset
//                bus      serial_adder_if.slave (start/a/b/cin in,
//                         busy/done/sum/cout[/ovf] out)
//  Parameters  : WIDTH    operand width, 2..32; must match the WIDTH of the
//                         connected interface instance
//  Config      : OVERFLOW_EN  adds the registered signed-overflow output ovf
//  Timing      : start accepted on edge 0, bits processed on edges 1..WIDTH,
//                done pulses in the cycle after edge WIDTH (WIDTH+1 clocks).
//                All outputs come straight from registers.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  wire            clk,
  input  wire            rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned       CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;     // operand A shift register
  logic [WIDTH-1:0]   sb_q, sb_d;     // operand B shift register
  logic [WIDTH-1:0]   sum_q, sum_d;   // result shift register (also the output)
  logic               c_q, c_d;       // running carry
  logic [CNT_W-1:0]   cnt_q, cnt_d;   // bits processed so far
  logic               cout_q, cout_d; // final carry, held with the result
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  // --------------------------------------------------------------------------
  // The single full-adder cell of the datapath
  // --------------------------------------------------------------------------
  wire fa_sum;
  wire fa_cout;

  full_adder_cell u_fa (
    .D1      (sa_q[0]),
    .D2      (sb_q[0]),
    .Cin     (c_q),
    .Sum_out (fa_sum),
    .Cout    (fa_cout)
  );

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
`ifdef OVERFLOW_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // sum/cout are deliberately left alone: the previous result stays
          // visible until the first bit edge of this operation.
          sa_d    = bus.a;
          sb_d    = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        sum_d = {fa_sum, sum_q[WIDTH-1:1]};
        c_d   = fa_cout;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // MSB edge: capture the final carry into its own holding register
          // so that reloading c with cin on the next start cannot disturb it.
          cout_d  = fa_cout;
`ifdef OVERFLOW_EN
          // Two's-complement overflow: carry into MSB differs from carry out.
          ovf_d   = c_q ^ fa_cout;
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the next state so that busy and
    // done change on the same edge as the state itself.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef OVERFLOW_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8). A table of
//                operand/result records plus a few hand-written multi-cycle
//                sequences; expected results are queued when an operation is
//                started and popped when done pulses.
//  Config      : OVERFLOW_EN  also checks ovf
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks    = 0;
  int   errors    = 0;
  int   done_seen = 0;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer addition, overflow from carry into MSB.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0]   full;
    logic [W-1:0] low;
    exp_t         m;
    full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    low  = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + W'(cin);
    m.s  = full[W-1:0];
    m.co = full[W];
    m.ov = low[W-1] ^ full[W];
    return m;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.done) begin
      done_seen++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        chk("sum", 32'(bus.sum), 32'(e.s));
        chk("cout", 32'(bus.cout), 32'(e.co));
`ifdef OVERFLOW_EN
        chk("ovf", 32'(bus.ovf), 32'(e.ov));
`endif
      end
    end
  end

  // Start one operation from IDLE and follow it to done. If inj > 0, a
  // stray start with a=b=1 is pulsed at that cycle of the run.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input exp_t e, input int inj);
    int lat;
    int d0;
    d0  = done_seen;
    lat = 0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
    sbq.push_back(e);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
      end
      if (i == inj) begin
        bus.a = 8'h01; bus.b = 8'h01; bus.start = 1'b1;
      end
      if (i == inj + 1) bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        break;
      end
    end
    chk("latency", 32'(lat), 32'(W + 1));
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("done_count", 32'(done_seen - d0), 32'd1);
  endtask

  vec_t tbl[8];

  initial begin
    int   t0;
    int   lat;
    int   d0;
    exp_t e;

    tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

    // Reset held for 3 cycles
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_done", 32'(done_seen), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Table-driven operations
    for (int i = 0; i < 8; i++) begin
      e = '{tbl[i].s, tbl[i].co, tbl[i].ov};
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, e, 0);
    end

    // Random operands against the model
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, model(ra, rb, rc), 0);
    end

    // Start during RUN is ignored: 10+20 with a stray 01+01 at cycle 4
    run_op(8'h10, 8'h20, 1'b0, '{8'h30, 1'b0, 1'b0}, 4);

    // Back-to-back: start held across the DONE cycle
    d0 = done_seen;
    @(negedge clk);
    bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
    sbq.push_back('{8'h10, 1'b0, 1'b0});
    @(negedge clk);
    bus.a = 8'hF0; bus.b = 8'h20;
    sbq.push_back('{8'h10, 1'b1, 1'b0});
    lat = 0;
    for (int i = 2; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done) begin lat = i; break; end
    end
    chk("b2b_first_latency", 32'(lat), 32'(W + 1));
    t0  = 0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("b2b_busy_restart", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
      end
      if (bus.done) begin lat = i; break; end
    end
    chk("b2b_spacing", 32'(lat), 32'(W + 1));
    @(negedge clk);
    chk("b2b_done_count", 32'(done_seen - d0), 32'd2);

    // Reset mid-RUN: abort, no done pulse, then a clean operation
    d0 = done_seen;
    @(negedge clk);
    bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0; bus.start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done_seen - d0), 32'd0);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    run_op(8'h01, 8'h02, 1'b0, '{8'h03, 1'b0, 1'b0}, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder
`default_nettype wire
